// File: rtl/multi_key_led_ctrl_if.sv
// -----------------------------------------------------------------------------
// multi_key_led_ctrl_if
// Bundle of the per-key signals exchanged between the key/LED controller and
// the board (or a testbench standing in for it).
//
//   key          raw asynchronous buttons, active-low (0 = pressed)
//   led          registered LED state, 1 = lit
//   held         debounced pressed level per key
//   short_pulse  one-cycle pulse on release of a press that never went long
//   long_pulse   one-cycle pulse when a hold reaches the long threshold
//
// Modports: master drives the buttons and observes the results,
//           slave is the controller itself.
// -----------------------------------------------------------------------------
interface multi_key_led_ctrl_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key;
    logic [NUM_KEYS-1:0] led;
    logic [NUM_KEYS-1:0] held;
    logic [NUM_KEYS-1:0] short_pulse;
    logic [NUM_KEYS-1:0] long_pulse;

    modport master (
        output key,
        input  led,
        input  held,
        input  short_pulse,
        input  long_pulse
    );

    modport slave (
        input  key,
        output led,
        output held,
        output short_pulse,
        output long_pulse
    );
endinterface

// File: rtl/multi_key_led_ctrl.sv
// -----------------------------------------------------------------------------
// multi_key_led_ctrl
// Debounces NUM_KEYS active-low buttons, classifies every press as short or
// long, and drives one LED per key: a short press toggles its own LED, any
// long press clears all LEDs.
//
//   clk      single clock, all logic on the rising edge
//   n_reset  synchronous active-low reset
//   bus      slave side of multi_key_led_ctrl_if (key in; led, held,
//            short_pulse, long_pulse out)
//
// Parameters:
//   NUM_KEYS     1..16 independent key channels
//   DEB_CYCLES   consecutive stable cycles needed to accept an edge (>= 2)
//   LONG_CYCLES  debounced hold cycles that qualify a long press (> DEB_CYCLES)
// -----------------------------------------------------------------------------
module multi_key_led_ctrl #(
    parameter int NUM_KEYS    = 4,
    parameter int DEB_CYCLES  = 1000000,
    parameter int LONG_CYCLES = 50000000
) (
    input  logic                 clk,
    input  logic                 n_reset,
    multi_key_led_ctrl_if.slave  bus
);

    localparam int DEB_W  = $clog2(DEB_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES);

    // The entry cycle into a debounce state already counts as the first stable
    // sample, so the counter only has to run to DEB_CYCLES-2.
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 2);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYCLES - 2);

    typedef enum logic [2:0] {
        IDLE,
        DB_DN,
        PRESSED,
        LONG,
        DB_UP
    } state_t;

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sk;
    logic [NUM_KEYS-1:0] held_vec;
    logic [NUM_KEYS-1:0] short_vec;
    logic [NUM_KEYS-1:0] long_vec;
    logic [NUM_KEYS-1:0] led_r;

    // Synchroniser resets to the released level so that a key still held at
    // reset release is seen as a fresh falling edge.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            sync1 <= '1;
            sk    <= '1;
        end else begin
            sync1 <= bus.key;
            sk    <= sync1;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        state_t            state, state_nxt;
        logic [DEB_W-1:0]  deb_cnt, deb_cnt_nxt;
        logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
        logic              long_flag, long_flag_nxt;
        logic              short_r, short_nxt;
        logic              long_r, long_nxt;

        always_ff @(posedge clk) begin
            if (!n_reset) begin
                state     <= IDLE;
                deb_cnt   <= '0;
                hold_cnt  <= '0;
                long_flag <= 1'b0;
                short_r   <= 1'b0;
                long_r    <= 1'b0;
            end else begin
                state     <= state_nxt;
                deb_cnt   <= deb_cnt_nxt;
                hold_cnt  <= hold_cnt_nxt;
                long_flag <= long_flag_nxt;
                short_r   <= short_nxt;
                long_r    <= long_nxt;
            end
        end

        // NOTE: every output of this block gets a default before the case so
        // no path leaves a signal unassigned and no latch is inferred.
        always_comb begin
            state_nxt     = state;
            deb_cnt_nxt   = deb_cnt;
            hold_cnt_nxt  = hold_cnt;
            long_flag_nxt = long_flag;
            short_nxt     = 1'b0;
            long_nxt      = 1'b0;
            case (state)
                IDLE: begin
                    if (!sk[i]) begin
                        state_nxt   = DB_DN;
                        deb_cnt_nxt = '0;
                    end
                end
                DB_DN: begin
                    if (sk[i]) begin
                        state_nxt = IDLE;
                    end else if (deb_cnt == DEB_LAST) begin
                        state_nxt     = PRESSED;
                        hold_cnt_nxt  = '0;
                        long_flag_nxt = 1'b0;
                    end else begin
                        deb_cnt_nxt = deb_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (sk[i]) begin
                        // Hold counter stays frozen while the release is
                        // being qualified, so a bounce does not lose time.
                        state_nxt   = DB_UP;
                        deb_cnt_nxt = '0;
                    end else if (hold_cnt == HOLD_PRE) begin
                        state_nxt     = LONG;
                        hold_cnt_nxt  = HOLD_LAST;
                        long_flag_nxt = 1'b1;
                        long_nxt      = 1'b1;
                    end else begin
                        hold_cnt_nxt = hold_cnt + 1'b1;
                    end
                end
                LONG: begin
                    if (sk[i]) begin
                        state_nxt   = DB_UP;
                        deb_cnt_nxt = '0;
                    end
                end
                DB_UP: begin
                    if (!sk[i]) begin
                        state_nxt = long_flag ? LONG : PRESSED;
                    end else if (deb_cnt == DEB_LAST) begin
                        state_nxt = IDLE;
                        short_nxt = !long_flag;
                    end else begin
                        deb_cnt_nxt = deb_cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        assign held_vec[i]  = (state == PRESSED) || (state == LONG) || (state == DB_UP);
        assign short_vec[i] = short_r;
        assign long_vec[i]  = long_r;
    end

    // Any long press wins over simultaneous short toggles.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            led_r <= '0;
        end else if (|long_vec) begin
            led_r <= '0;
        end else begin
            led_r <= led_r ^ short_vec;
        end
    end

    assign bus.led         = led_r;
    assign bus.held        = held_vec;
    assign bus.short_pulse = short_vec;
    assign bus.long_pulse  = long_vec;

endmodule

// File: tb/tb_multi_key_led_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multi_key_led_ctrl
// Drives the key controller with directed press scenarios and random key
// activity, and compares every output every cycle against a rule-level model
// of debounce, hold timing and LED behaviour.
// -----------------------------------------------------------------------------
module tb_multi_key_led_ctrl;

    localparam int NK   = 4;
    localparam int DEB  = 4;
    localparam int LONG = 20;

    logic clk = 1'b0;
    logic n_reset = 1'b0;

    always #5 clk = ~clk;

    multi_key_led_ctrl_if #(.NUM_KEYS(NK)) bus_if ();

    multi_key_led_ctrl #(
        .NUM_KEYS    (NK),
        .DEB_CYCLES  (DEB),
        .LONG_CYCLES (LONG)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus_if)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: two-stage input delay, debounced level, and for
    // each key the run of samples disagreeing with it plus accumulated hold.
    logic [NK-1:0] p0 = '1, p1 = '1;
    logic [NK-1:0] m_led = '0, m_held = '0, m_sp = '0, m_lp = '0;
    int            run   [NK];
    int            hold  [NK];
    bit            longf [NK];

    logic [4*NK-1:0] obs, expv;
    assign obs  = {bus_if.led, bus_if.held, bus_if.short_pulse, bus_if.long_pulse};
    assign expv = {m_led, m_held, m_sp, m_lp};

    task automatic model_edge();
        logic [NK-1:0] s;
        if (!n_reset) begin
            m_led = '0; m_held = '0; m_sp = '0; m_lp = '0;
            p0 = '1; p1 = '1;
            for (int k = 0; k < NK; k++) begin
                run[k] = 0; hold[k] = 0; longf[k] = 0;
            end
        end else begin
            s = p1;
            if (|m_lp) m_led = '0;
            else       m_led = m_led ^ m_sp;
            m_sp = '0;
            m_lp = '0;
            for (int k = 0; k < NK; k++) begin
                if (!m_held[k]) begin
                    run[k] = s[k] ? 0 : run[k] + 1;
                    if (run[k] == DEB) begin
                        m_held[k] = 1'b1; run[k] = 0; hold[k] = 0; longf[k] = 0;
                    end
                end else if (s[k]) begin
                    run[k] = run[k] + 1;
                    if (run[k] == DEB) begin
                        m_held[k] = 1'b0; run[k] = 0;
                        if (!longf[k]) m_sp[k] = 1'b1;
                    end
                end else if (run[k] != 0) begin
                    run[k] = 0;
                end else if (!longf[k]) begin
                    hold[k] = hold[k] + 1;
                    if (hold[k] == LONG - 1) begin
                        longf[k] = 1; m_lp[k] = 1'b1;
                    end
                end
            end
            p1 = p0;
            p0 = bus_if.key;
        end
    endtask

    // Advance one clock; the model sees the same pre-edge inputs as the DUT
    // and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        bus_if.key = '1;
        for (int t = 0; t < 3; t++) begin
            tick();
            compared++;
            if (obs !== '0) begin
                mismatched++;
                $display("FAIL reset_outputs t=%0t got=%h want=0", $time, obs);
            end
        end
        n_reset = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick();
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("FAIL reset_idle t=%0t got=%h want=%h", $time, obs, expv);
            end
        end
    endtask

    task automatic test_short_press();
        int rise_at = 0;
        int sp_at   = 0;
        logic [NK-1:0] led_seen = '0;
        bus_if.key[0] = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("FAIL short_press t=%0t got=%h want=%h", $time, obs, expv);
            end
            if (rise_at == 0 && bus_if.held[0]) rise_at = t;
        end
        bus_if.key[0] = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("FAIL short_release t=%0t got=%h want=%h", $time, obs, expv);
            end
            if (sp_at == 0 && bus_if.short_pulse[0]) sp_at = t;
            if (t == 7) led_seen = bus_if.led;
        end
        compared++;
        if (rise_at !== 6) begin
            mismatched++;
            $display("FAIL held_rise_latency got=%0d want=6", rise_at);
        end
        compared++;
        if (sp_at !== 6) begin
            mismatched++;
            $display("FAIL short_pulse_latency got=%0d want=6", sp_at);
        end
        compared++;
        if (led_seen !== 4'b0001) begin
            mismatched++;
            $display("FAIL short_led got=%b want=0001", led_seen);
        end
    endtask

    task automatic test_glitch();
        for (int t = 1; t <= 12; t++) begin
            bus_if.key[1] = (t <= 3) ? 1'b0 : 1'b1;
            tick();
            compared++;
            if (obs !== {4'b0001, 12'h000} || obs !== expv) begin
                mismatched++;
                $display("FAIL glitch t=%0t got=%h want=%h", $time, obs, {4'b0001, 12'h000});
            end
        end
    endtask

    task automatic test_long_press();
        int lp_cnt = 0;
        int lp_at  = 0;
        int sp_cnt = 0;
        logic [NK-1:0] led_after = '1;
        for (int t = 1; t <= 16; t++) begin
            bus_if.key[1] = (t <= 8) ? 1'b0 : 1'b1;
            tick();
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("FAIL setup_key1 t=%0t got=%h want=%h", $time, obs, expv);
            end
        end
        compared++;
        if (bus_if.led !== 4'b0011) begin
            mismatched++;
            $display("FAIL led_before_long got=%b want=0011", bus_if.led);
        end
        for (int t = 1; t <= 52; t++) begin
            bus_if.key[2] = (t <= 40) ? 1'b0 : 1'b1;
            tick();
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("FAIL long_press t=%0t got=%h want=%h", $time, obs, expv);
            end
            if (bus_if.long_pulse[2]) begin
                lp_cnt++;
                lp_at = t;
            end
            if (bus_if.short_pulse[2]) sp_cnt++;
            if (t == 26) led_after = bus_if.led;
        end
        compared++;
        if (lp_cnt !== 1 || lp_at !== 25) begin
            mismatched++;
            $display("FAIL long_pulse count=%0d at=%0d want count=1 at=25", lp_cnt, lp_at);
        end
        compared++;
        if (sp_cnt !== 0) begin
            mismatched++;
            $display("FAIL long_no_short got=%0d want=0", sp_cnt);
        end
        compared++;
        if (led_after !== 4'b0000) begin
            mismatched++;
            $display("FAIL long_clears_led got=%b want=0000", led_after);
        end
    endtask

    task automatic test_simultaneous();
        logic [NK-1:0] sp_seen = '0;
        for (int t = 1; t <= 16; t++) begin
            bus_if.key = (t <= 8) ? 4'b0110 : 4'b1111;
            tick();
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("FAIL simultaneous t=%0t got=%h want=%h", $time, obs, expv);
            end
            if (sp_seen == '0) sp_seen = bus_if.short_pulse;
        end
        compared++;
        if (sp_seen !== 4'b1001 || bus_if.led !== 4'b1001) begin
            mismatched++;
            $display("FAIL simultaneous_led sp=%b led=%b want 1001/1001", sp_seen, bus_if.led);
        end
    endtask

    task automatic test_bounce();
        int lp_cnt = 0;
        int sp_cnt = 0;
        int drops  = 0;
        for (int t = 1; t <= 62; t++) begin
            bus_if.key[0] = (t <= 16 || (t >= 19 && t <= 50)) ? 1'b0 : 1'b1;
            tick();
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("FAIL bounce t=%0t got=%h want=%h", $time, obs, expv);
            end
            if (bus_if.long_pulse[0]) lp_cnt++;
            if (bus_if.short_pulse[0]) sp_cnt++;
            if (t >= 6 && t <= 55 && !bus_if.held[0]) drops++;
        end
        compared++;
        if (lp_cnt !== 1 || sp_cnt !== 0 || drops !== 0) begin
            mismatched++;
            $display("FAIL bounce_summary long=%0d short=%0d drops=%0d want 1/0/0", lp_cnt, sp_cnt, drops);
        end
    endtask

    task automatic test_reset_mid_press();
        int rise_at = 0;
        bus_if.key[1] = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("FAIL mid_press t=%0t got=%h want=%h", $time, obs, expv);
            end
        end
        n_reset = 1'b0;
        tick();
        compared++;
        if (obs !== '0) begin
            mismatched++;
            $display("FAIL mid_reset_outputs got=%h want=0", obs);
        end
        n_reset = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("FAIL after_reset t=%0t got=%h want=%h", $time, obs, expv);
            end
            if (rise_at == 0 && bus_if.held[1]) rise_at = t;
        end
        compared++;
        if (rise_at !== 6) begin
            mismatched++;
            $display("FAIL reheld_latency got=%0d want=6", rise_at);
        end
        bus_if.key[1] = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("FAIL after_reset_release t=%0t got=%h want=%h", $time, obs, expv);
            end
        end
    endtask

    task automatic test_random();
        int dwell [NK];
        for (int k = 0; k < NK; k++) dwell[k] = $urandom_range(1, 35);
        for (int t = 0; t < 3000; t++) begin
            for (int k = 0; k < NK; k++) begin
                dwell[k]--;
                if (dwell[k] <= 0) begin
                    bus_if.key[k] = ~bus_if.key[k];
                    dwell[k] = $urandom_range(1, 35);
                end
            end
            n_reset = ($urandom_range(0, 499) != 0);
            tick();
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("FAIL random t=%0t got=%h want=%h", $time, obs, expv);
            end
        end
        n_reset = 1'b1;
    endtask

    initial begin
        bus_if.key = '1;
        for (int k = 0; k < NK; k++) begin
            run[k] = 0; hold[k] = 0; longf[k] = 0;
        end
        #2;
        test_reset();
        test_short_press();
        test_glitch();
        test_long_press();
        test_simultaneous();
        test_bounce();
        test_reset_mid_press();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multi_key_led_ctrl.md
MULTI_KEY_LED_CTRL -- requirements
Module: multi_key_led_ctrl

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4: number of independent key channels, legal range 1..16.
REQ-002 SHALL have parameter DEB_CYCLES, default 1000000: stable-level cycles required to accept a key edge (20 ms at 50 MHz), legal minimum 2.
REQ-003 SHALL have parameter LONG_CYCLES, default 50000000: debounced hold cycles that qualify a long press (1 s at 50 MHz), legal only when greater than DEB_CYCLES.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port n_reset, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port key, input, NUM_KEYS bits: raw asynchronous buttons, active-low (0 = pressed).
REQ-007 SHALL have port led, output, NUM_KEYS bits: registered LED state, 1 = lit.
REQ-008 SHALL have port held, output, NUM_KEYS bits: debounced pressed level per key.
REQ-009 SHALL have port short_pulse, output, NUM_KEYS bits: one-cycle pulse on release of a press that did not reach long.
REQ-010 SHALL have port long_pulse, output, NUM_KEYS bits: one-cycle pulse when a hold reaches LONG_CYCLES.

Function
REQ-011 SHALL pass each key bit through a 2-flop synchroniser; only its output (sk) feeds the FSMs.
REQ-012 SHALL implement one independent FSM per key with states IDLE, DB_DN, PRESSED, LONG, DB_UP, a debounce counter, a hold counter, and a long flag.
REQ-013 IDLE: sk=0 -> DB_DN, debounce counter cleared.
REQ-014 DB_DN: sk=1 -> IDLE; otherwise count; after DEB_CYCLES consecutive sk=0 cycles -> PRESSED, held=1, hold counter cleared, long flag cleared.
REQ-015 PRESSED: hold counter increments each cycle; on the cycle it reaches LONG_CYCLES-1 -> LONG, long flag set, long_pulse=1 for exactly that one cycle.
REQ-016 PRESSED or LONG: sk=1 -> DB_UP, debounce counter cleared, held stays 1, hold counter frozen.
REQ-017 DB_UP: sk=0 -> return to LONG if long flag set, else PRESSED with hold counter resuming from its frozen value; after DEB_CYCLES consecutive sk=1 cycles -> IDLE, held=0, and short_pulse=1 for one cycle only if long flag clear.
REQ-018 A single press SHALL produce exactly one of short_pulse or long_pulse, never both, never repeated.
REQ-019 Glitches shorter than DEB_CYCLES SHALL produce no change on held, short_pulse, long_pulse or led.
REQ-020 held rise latency SHALL be exactly 2+DEB_CYCLES cycles after a stable key fall; held fall latency the same after a stable key rise.
REQ-021 LED update, registered, one cycle after the pulse: short_pulse[i] toggles led[i]; any long_pulse bit clears all led bits.
REQ-022 Simultaneous short pulses on several keys SHALL toggle each corresponding LED in the same cycle.
REQ-023 Long and short pulses in the same cycle: clear wins, led = 0.
REQ-024 Counters SHALL be sized $clog2 of their limit, saturate rather than wrap, and never overflow.

Reset
REQ-025 n_reset=0 sampled on a clk edge SHALL force:
- all FSMs to IDLE, all counters and long flags to 0
- synchroniser flops to 1 (released)
- led, held, short_pulse and long_pulse to 0
REQ-026 Reset asserted mid-press SHALL emit no pulse.
REQ-027 After reset release, a key still held low SHALL be treated as a new press: held rises 2+DEB_CYCLES cycles later.

Verification (NUM_KEYS=4, DEB_CYCLES=4, LONG_CYCLES=20)
REQ-028 Key0 low for 10 cycles, then high -> held[0]=1 at cycle 6; short_pulse[0] one cycle at 6 cycles after release; led=4'b0001 one cycle later.
REQ-029 Key1 low for 3 cycles (glitch) -> held, pulses and led unchanged.
REQ-030 Key2 low for 40 cycles -> long_pulse[2] one cycle; no short_pulse on release; led cleared to 0 from 4'b0011.
REQ-031 Key0 and key3 short-pressed together from led=0 -> short_pulse=4'b1001 same cycle; led=4'b1001.
REQ-032 Key0 held with a 2-cycle high bounce at hold cycle 10 -> single long_pulse; held never drops.
REQ-033 n_reset=0 for 1 cycle while key1 held 8 cycles -> all outputs 0 next cycle; no pulse; held[1] returns 6 cycles after reset release.
